// File: rtl/salu_sequencer.sv
// Issue stage in front of the 8-bit salu: buffers {load, op, opb} operations in a
// small FIFO, issues them one at a time and writes the salu result back into acc.
module salu_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_opb,
  output logic [WIDTH-1:0] alu_opa,
  output logic [WIDTH-1:0] alu_opb,
  output logic [2:0]       alu_mux,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             out_valid,
  output logic [7:0]       op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [EW-1:0]    head;

  logic             iss_load;
  logic [2:0]       iss_op;
  logic [WIDTH-1:0] iss_opb;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_load, in_op, in_opb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Issue register: holds the last popped operation until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_load <= 1'b0;
      iss_op   <= '0;
      iss_opb  <= '0;
    end else if (pop) begin
      {iss_load, iss_op, iss_opb} <= head;
    end
  end

  // Writeback at the edge that closes EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      op_count <= '0;
    end else if (state == EXEC) begin
      acc      <= iss_load ? iss_opb : alu_result;
      op_count <= op_count + 8'd1;
    end
  end

  assign alu_opa   = acc;
  assign alu_opb   = iss_opb;
  assign alu_mux   = iss_op;
  assign zero      = (acc == '0);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_salu_sequencer.sv
// Randomized and directed bench for salu_sequencer with an adder stub in place of salu
// and a transaction-level scoreboard model of the accumulator.
module tb_salu_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_opb;
  logic [WIDTH-1:0] alu_opa;
  logic [WIDTH-1:0] alu_opb;
  logic [2:0]       alu_mux;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc;
  logic             zero;
  logic             out_valid;
  logic [7:0]       op_count;

  typedef struct packed {
    logic       load;
    logic [2:0] op;
    logic [7:0] opb;
  } op_t;

  op_t        q[$];
  op_t        mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses   = 0;
  int         p0;
  logic [7:0] c0;
  logic [7:0] exp_acc  = 8'h00;
  logic [7:0] exp_cnt  = 8'h00;
  logic       prev_ov  = 1'b0;

  salu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_load   (in_load),
    .in_op     (in_op),
    .in_opb    (in_opb),
    .alu_opa   (alu_opa),
    .alu_opb   (alu_opb),
    .alu_mux   (alu_mux),
    .alu_result(alu_result),
    .acc       (acc),
    .zero      (zero),
    .out_valid (out_valid),
    .op_count  (op_count)
  );

  assign alu_result = alu_opa + alu_opb;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every accepted operation joins the scoreboard in arrival order.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      q.push_back(op_t'({in_load, in_op, in_opb}));
    end
  end

  // Each out_valid pulse retires the oldest accepted operation.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_acc = 8'h00;
      exp_cnt = 8'h00;
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        pulses++;
        if (q.size() == 0) begin
          chk("pulse_unexpected", 1, 0);
        end else begin
          mon_e   = q.pop_front();
          exp_acc = mon_e.load ? mon_e.opb : 8'(exp_acc + mon_e.opb);
          exp_cnt = exp_cnt + 8'd1;
          chk("res_opb", alu_opb, mon_e.opb);
          chk("res_mux", alu_mux, mon_e.op);
        end
      end
      chk("acc", acc, exp_acc);
      chk("op_count", op_count, exp_cnt);
      chk("zero", zero, exp_acc == 8'h00);
      chk("opa_eq_acc", alu_opa, acc);
      chk("ov_double", out_valid && prev_ov, 0);
      prev_ov = out_valid;
    end
  end

  task automatic push(input logic l, input logic [2:0] o, input logic [7:0] b);
    int g = 0;
    in_load  = l;
    in_op    = o;
    in_opb   = b;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) chk("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    chk("drain_timeout", g < 300, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with in_valid asserted
    rst      = 1'b1;
    in_valid = 1'b1;
    in_load  = 1'b0;
    in_op    = 3'd3;
    in_opb   = 8'h77;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    chk("rst_acc", acc, 8'h00);
    chk("rst_zero", zero, 1);
    chk("rst_count", op_count, 0);
    chk("rst_opb", alu_opb, 0);
    chk("rst_mux", alu_mux, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_pulse", pulses, 0);

    // Load then op, including first-operation latency
    p0 = pulses;
    push(1'b1, 3'd0, 8'h6A);
    push(1'b0, 3'd1, 8'h3B);
    @(negedge clk); #1;
    chk("lat_exec_ov", out_valid, 0);
    chk("lat_exec_opb", alu_opb, 8'h6A);
    @(negedge clk); #1;
    chk("lat_done_ov", out_valid, 1);
    chk("load_acc", acc, 8'h6A);
    @(negedge clk); #1;
    chk("exec2_ov", out_valid, 0);
    chk("exec2_opa", alu_opa, 8'h6A);
    chk("exec2_opb", alu_opb, 8'h3B);
    chk("exec2_mux", alu_mux, 3'd1);
    @(negedge clk); #1;
    chk("done2_ov", out_valid, 1);
    chk("op_acc", acc, 8'hA5);
    chk("op_count2", op_count, 2);
    repeat (4) @(negedge clk);
    #1;
    chk("two_pulses", pulses - p0, 2);
    drain();

    // Arithmetic wrap and op_count wrap
    push(1'b1, 3'd0, 8'hF0);
    push(1'b0, 3'd5, 8'h10);
    drain();
    chk("wrap_acc", acc, 8'h00);
    chk("wrap_zero", zero, 1);
    c0 = op_count;
    repeat (256) push($urandom_range(0, 3) == 0, 3'($urandom), 8'($urandom));
    drain();
    chk("count_wrap", op_count, c0);

    // Fill the FIFO with a continuous stream
    p0       = pulses;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_load = (i == 0);
      in_op   = 3'(i);
      in_opb  = 8'($urandom);
      @(posedge clk);
      #1;
      if (i == 5) chk("ready_occ3", in_ready, 1);
      if (i == 6) chk("full_ready", in_ready, 0);
      if (i == 7) chk("ready_after_pop", in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("full_pulses6", pulses - p0, 6);
    @(negedge clk);
    #1;
    chk("full_pulses7", pulses - p0, 7);
    drain();
    chk("full_total", pulses - p0, 7);

    // Push on a pop edge at occupancy 2
    p0       = pulses;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_load = 1'b0;
      in_op   = 3'(i + 2);
      in_opb  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    chk("simul_ready", in_ready, 1);
    in_valid = 1'b0;
    drain();
    chk("simul_pulses", pulses - p0, 4);

    // Reset during EXEC with a queued follower
    push(1'b1, 3'd0, 8'h11);
    drain();
    chk("pre_rst_acc", acc, 8'h11);
    push(1'b0, 3'd2, 8'h55);
    push(1'b0, 3'd3, 8'h22);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc", acc, 8'h00);
    chk("arst_zero", zero, 1);
    chk("arst_count", op_count, 0);
    chk("arst_ov", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_opb", alu_opb, 0);
    chk("arst_mux", alu_mux, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    p0  = pulses;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_pulses", pulses - p0, 0);
    chk("post_rst_acc", acc, 8'h00);
    chk("post_rst_count", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
